// File: rtl/l1_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : l1_wb_arbiter
// Description : Shares one pipelined Wishbone master between L1I line fills
//               and L1D fills / non-cacheable reads / write-through stores.
// Revision    : 1.0 - initial release
// ============================================================================
module l1_wb_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic                         wb_clk_i,
    input  logic                         wb_rst_i,
    input  logic                         l1i_req_val,
    input  logic [ADDR_W-1:0]            l1i_req_addr,
    output logic                         l1i_req_ack,
    output logic [LINE_WORDS*DATA_W-1:0] l1i_ack_data,
    input  logic                         l1d_req_val,
    input  logic                         l1d_req_we,
    input  logic                         l1d_req_nc,
    input  logic [ADDR_W-1:0]            l1d_req_addr,
    input  logic [DATA_W-1:0]            l1d_req_wdata,
    input  logic [DATA_W/8-1:0]          l1d_req_be,
    output logic                         l1d_req_ack,
    output logic [LINE_WORDS*DATA_W-1:0] l1d_ack_data,
    output logic                         l1d_ack_nc,
    output logic                         l1d_ack_we,
    input  logic [DATA_W-1:0]            wb_dat_i,
    input  logic                         wb_ack_i,
    input  logic                         wb_stall_i,
    output logic [DATA_W-1:0]            wb_dat_o,
    output logic [ADDR_W-1:0]            wb_adr_o,
    output logic [DATA_W/8-1:0]          wb_sel_o,
    output logic                         wb_cyc_o,
    output logic                         wb_stb_o,
    output logic                         wb_we_o
);

    localparam int c_sel_w  = DATA_W / 8;
    localparam int c_line_w = LINE_WORDS * DATA_W;
    localparam int c_cnt_w  = $clog2(LINE_WORDS) + 1;
    localparam logic [ADDR_W-1:0] c_line_mask = ADDR_W'(LINE_WORDS * c_sel_w - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t               r_state;
    logic                 r_gnt_d;
    logic                 r_prio_d;
    logic [ADDR_W-1:0]    r_addr;
    logic                 r_we;
    logic                 r_nc;
    logic [DATA_W-1:0]    r_wdata;
    logic [c_sel_w-1:0]   r_be;
    logic [c_cnt_w-1:0]   r_beats;
    logic [c_cnt_w-1:0]   r_issue_cnt;
    logic [c_cnt_w-1:0]   r_ack_cnt;
    logic [c_line_w-1:0]  r_line;
    logic                 r_cyc;
    logic                 r_stb;
    logic                 r_wb_we;
    logic [ADDR_W-1:0]    r_adr;
    logic [c_sel_w-1:0]   r_sel;
    logic [DATA_W-1:0]    r_dat;
    logic                 r_l1i_ack;
    logic                 r_l1d_ack;

    logic                 w_pick_d;
    logic                 w_single;
    logic [ADDR_W-1:0]    w_line_base;
    logic [c_cnt_w-1:0]   w_issue_nxt;
    logic [c_cnt_w-1:0]   w_ack_nxt;
    logic                 w_ack_take;

    // Round robin: L1D wins a tie only when L1I was the last one served.
    assign w_pick_d    = l1d_req_val && (!l1i_req_val || r_prio_d);
    assign w_single    = (r_beats == c_cnt_w'(1));
    assign w_line_base = r_addr & ~c_line_mask;
    assign w_issue_nxt = r_issue_cnt + c_cnt_w'(1);
    assign w_ack_nxt   = r_ack_cnt + c_cnt_w'(1);
    // Acks beyond the number of accepted beats are spurious and dropped.
    assign w_ack_take  = wb_ack_i && (r_state == ST_ISSUE || r_state == ST_WAIT)
                         && (r_ack_cnt < r_issue_cnt);

    function automatic logic [ADDR_W-1:0] beat_adr(
        input logic                single,
        input logic [ADDR_W-1:0]   addr,
        input logic [ADDR_W-1:0]   base,
        input logic [c_cnt_w-1:0]  idx
    );
        return single ? addr : base + ADDR_W'(idx) * ADDR_W'(c_sel_w);
    endfunction

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state     <= ST_IDLE;
            r_gnt_d     <= 1'b0;
            r_prio_d    <= 1'b0;
            r_addr      <= '0;
            r_we        <= 1'b0;
            r_nc        <= 1'b0;
            r_wdata     <= '0;
            r_be        <= '0;
            r_beats     <= '0;
            r_issue_cnt <= '0;
            r_ack_cnt   <= '0;
            r_line      <= '0;
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_wb_we     <= 1'b0;
            r_adr       <= '0;
            r_sel       <= '0;
            r_dat       <= '0;
            r_l1i_ack   <= 1'b0;
            r_l1d_ack   <= 1'b0;
        end else begin
            r_l1i_ack <= 1'b0;
            r_l1d_ack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (l1i_req_val || l1d_req_val) begin
                        r_gnt_d     <= w_pick_d;
                        r_addr      <= w_pick_d ? l1d_req_addr : l1i_req_addr;
                        r_we        <= w_pick_d && l1d_req_we;
                        r_nc        <= w_pick_d && l1d_req_nc;
                        r_wdata     <= l1d_req_wdata;
                        r_be        <= l1d_req_be;
                        r_beats     <= (w_pick_d && (l1d_req_we || l1d_req_nc)) ?
                                       c_cnt_w'(1) : c_cnt_w'(LINE_WORDS);
                        r_issue_cnt <= '0;
                        r_ack_cnt   <= '0;
                        r_line      <= '0;
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // stb is low only on the first ISSUE cycle; present beat 0 then.
                    if (!r_stb) begin
                        r_cyc   <= 1'b1;
                        r_stb   <= 1'b1;
                        r_wb_we <= r_we;
                        r_adr   <= beat_adr(w_single, r_addr, w_line_base, '0);
                        r_sel   <= r_we ? r_be : '1;
                        r_dat   <= r_wdata;
                    end else if (!wb_stall_i) begin
                        r_issue_cnt <= w_issue_nxt;
                        if (w_issue_nxt == r_beats) begin
                            r_stb   <= 1'b0;
                            r_state <= ST_WAIT;
                        end else begin
                            r_adr <= beat_adr(w_single, r_addr, w_line_base, w_issue_nxt);
                        end
                    end
                end
                ST_DONE: begin
                    r_prio_d <= ~r_gnt_d;
                    r_state  <= ST_IDLE;
                end
                default: begin
                end
            endcase

            if (w_ack_take) begin
                r_ack_cnt <= w_ack_nxt;
                if (!r_we) begin
                    for (int w = 0; w < LINE_WORDS; w++) begin
                        if (r_ack_cnt == c_cnt_w'(w)) begin
                            r_line[w*DATA_W +: DATA_W] <= wb_dat_i;
                        end
                    end
                end
                if (w_ack_nxt == r_beats) begin
                    r_state   <= ST_DONE;
                    r_cyc     <= 1'b0;
                    r_stb     <= 1'b0;
                    r_wb_we   <= 1'b0;
                    r_l1i_ack <= ~r_gnt_d;
                    r_l1d_ack <= r_gnt_d;
                end
            end
        end
    end

    assign l1i_req_ack  = r_l1i_ack;
    assign l1d_req_ack  = r_l1d_ack;
    assign l1i_ack_data = r_line;
    assign l1d_ack_data = r_line;
    assign l1d_ack_nc   = r_nc;
    assign l1d_ack_we   = r_we;
    assign wb_cyc_o     = r_cyc;
    assign wb_stb_o     = r_stb;
    assign wb_we_o      = r_wb_we;
    assign wb_adr_o     = r_adr;
    assign wb_sel_o     = r_sel;
    assign wb_dat_o     = r_dat;

endmodule
`default_nettype wire

// File: tb/tb_l1_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_l1_wb_arbiter
// Description : Scoreboard bench for l1_wb_arbiter with a pipelined WB slave.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_l1_wb_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         l1i_req_val = 1'b0;
    logic [31:0]  l1i_req_addr = '0;
    logic         l1i_req_ack;
    logic [127:0] l1i_ack_data;
    logic         l1d_req_val = 1'b0;
    logic         l1d_req_we = 1'b0;
    logic         l1d_req_nc = 1'b0;
    logic [31:0]  l1d_req_addr = '0;
    logic [31:0]  l1d_req_wdata = '0;
    logic [3:0]   l1d_req_be = '0;
    logic         l1d_req_ack;
    logic [127:0] l1d_ack_data;
    logic         l1d_ack_nc;
    logic         l1d_ack_we;
    logic [31:0]  wb_dat_i = '0;
    logic         wb_ack_i = 1'b0;
    logic         wb_stall_i;
    logic [31:0]  wb_dat_o;
    logic [31:0]  wb_adr_o;
    logic [3:0]   wb_sel_o;
    logic         wb_cyc_o;
    logic         wb_stb_o;
    logic         wb_we_o;

    always #5 clk = ~clk;

    l1_wb_arbiter #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(4)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .l1i_req_val(l1i_req_val), .l1i_req_addr(l1i_req_addr),
        .l1i_req_ack(l1i_req_ack), .l1i_ack_data(l1i_ack_data),
        .l1d_req_val(l1d_req_val), .l1d_req_we(l1d_req_we), .l1d_req_nc(l1d_req_nc),
        .l1d_req_addr(l1d_req_addr), .l1d_req_wdata(l1d_req_wdata), .l1d_req_be(l1d_req_be),
        .l1d_req_ack(l1d_req_ack), .l1d_ack_data(l1d_ack_data),
        .l1d_ack_nc(l1d_ack_nc), .l1d_ack_we(l1d_ack_we),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_stall_i(wb_stall_i),
        .wb_dat_o(wb_dat_o), .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o)
    );

    typedef struct {
        logic [31:0] adr;
        logic [3:0]  sel;
        logic        we;
        logic [31:0] dat;
        int          hold;
        bit          held_ok;
    } beat_t;

    typedef struct {
        bit           is_d;
        logic [127:0] data;
        logic         nc;
        logic         we;
        int           cyc;
    } ack_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } pend_t;

    beat_t beat_log[$];
    beat_t exp_beats[$];
    ack_t  ack_log[$];
    ack_t  exp_acks[$];
    pend_t pend[$];

    int n_cmp = 0;
    int n_fail = 0;
    int cyc_cnt = 0;
    int t0 = 0;
    int ack_seen = 0;
    int acks_sent = 0;
    int stall_beat = -1;
    int stall_len = 0;
    int ack_delay = 1;
    int acc_beats = 0;
    int stall_used = 0;
    int cur_hold = 0;
    logic [31:0] hold_adr = '0;
    bit hold_ok = 1'b1;
    logic [31:0] slave_data_base = '0;

    function automatic logic [31:0] rd_model(input logic [31:0] a);
        return slave_data_base + (a >> 2);
    endfunction

    assign wb_stall_i = wb_stb_o && (acc_beats == stall_beat) && (stall_used < stall_len);

    // Pipelined slave: accepts a beat on stb & !stall, acks ack_delay cycles later.
    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (rst) begin
            pend.delete();
            wb_ack_i   <= 1'b0;
            acc_beats  <= 0;
            stall_used <= 0;
            cur_hold = 0;
        end else begin
            if (!wb_cyc_o) begin
                acc_beats  <= 0;
                stall_used <= 0;
                cur_hold = 0;
            end else if (wb_stb_o) begin
                if (cur_hold == 0) begin
                    hold_adr = wb_adr_o;
                    hold_ok  = 1'b1;
                end else if (wb_adr_o !== hold_adr) begin
                    hold_ok = 1'b0;
                end
                cur_hold++;
                if (wb_stall_i) begin
                    stall_used <= stall_used + 1;
                end else begin
                    beat_log.push_back('{wb_adr_o, wb_sel_o, wb_we_o, wb_dat_o, cur_hold, hold_ok});
                    pend.push_back('{cyc_cnt + ack_delay, rd_model(wb_adr_o)});
                    acc_beats <= acc_beats + 1;
                    cur_hold = 0;
                end
            end
            if (pend.size() > 0 && pend[0].due <= cyc_cnt + 1) begin
                wb_ack_i <= 1'b1;
                wb_dat_i <= pend[0].data;
                acks_sent++;
                void'(pend.pop_front());
            end else begin
                wb_ack_i <= 1'b0;
                wb_dat_i <= 32'hDEAD0000;
            end
        end
    end

    always @(negedge clk) begin
        if (l1i_req_ack) ack_log.push_back('{1'b0, l1i_ack_data, 1'b0, 1'b0, cyc_cnt});
        if (l1d_req_ack) ack_log.push_back('{1'b1, l1d_ack_data, l1d_ack_nc, l1d_ack_we, cyc_cnt});
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        beat_log.delete();
        ack_log.delete();
        exp_beats.delete();
        exp_acks.delete();
        ack_seen = 0;
    endtask

    // Waits (bounded) for n acks; each requester drops val once acked.
    task automatic wait_acks(input int n);
        for (int i = 0; i < 300 && ack_seen < n; i++) begin
            @(negedge clk);
            #1;
            while (ack_seen < ack_log.size()) begin
                if (ack_log[ack_seen].is_d) l1d_req_val = 1'b0;
                else                        l1i_req_val = 1'b0;
                ack_seen++;
            end
        end
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ctrl: cyc/stb/we=%b required 000", {wb_cyc_o, wb_stb_o, wb_we_o});
        end
        n_cmp++;
        if ({wb_adr_o, wb_sel_o, wb_dat_o} !== 68'h0) begin
            n_fail++;
            $display("FAIL reset_bus: adr=%h sel=%h dat=%h required 0", wb_adr_o, wb_sel_o, wb_dat_o);
        end
        n_cmp++;
        if ({l1i_req_ack, l1d_req_ack, l1d_ack_nc, l1d_ack_we} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_acks: %b required 0000",
                     {l1i_req_ack, l1d_req_ack, l1d_ack_nc, l1d_ack_we});
        end
        n_cmp++;
        if ({l1i_ack_data, l1d_ack_data} !== 256'h0) begin
            n_fail++;
            $display("FAIL reset_data: i=%h d=%h required 0", l1i_ack_data, l1d_ack_data);
        end
        @(negedge clk);
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_fill();
        beat_t eb;
        ack_t ea;
        clear_logs();
        slave_data_base = 32'hA0 - (32'h100 >> 2);
        for (int i = 0; i < 4; i++) exp_beats.push_back('{32'h100 + 4*i, 4'hF, 1'b0, 32'h0, 1, 1'b1});
        exp_acks.push_back('{1'b0, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 1'b0, 1'b0, 7});
        @(negedge clk);
        l1i_req_addr = 32'h100;
        l1i_req_val  = 1'b1;
        t0 = cyc_cnt;
        wait_acks(1);
        n_cmp++;
        if (ack_log.size() != 1 || beat_log.size() != 4) begin
            n_fail++;
            $display("FAIL fill_count: acks=%0d beats=%0d required 1/4", ack_log.size(), beat_log.size());
        end
        while (exp_beats.size() > 0 && beat_log.size() > 0) begin
            eb = exp_beats.pop_front();
            n_cmp++;
            if (beat_log[0].adr !== eb.adr || beat_log[0].sel !== eb.sel || beat_log[0].we !== eb.we) begin
                n_fail++;
                $display("FAIL fill_beat: adr=%h sel=%h we=%b required adr=%h sel=%h we=%b",
                         beat_log[0].adr, beat_log[0].sel, beat_log[0].we, eb.adr, eb.sel, eb.we);
            end
            void'(beat_log.pop_front());
        end
        if (ack_log.size() > 0) begin
            ea = exp_acks.pop_front();
            n_cmp++;
            if (ack_log[0].is_d !== ea.is_d || ack_log[0].data !== ea.data) begin
                n_fail++;
                $display("FAIL fill_data: d=%b data=%h required d=%b data=%h",
                         ack_log[0].is_d, ack_log[0].data, ea.is_d, ea.data);
            end
            n_cmp++;
            if (ack_log[0].cyc - t0 != ea.cyc) begin
                n_fail++;
                $display("FAIL fill_latency: %0d cycles required %0d", ack_log[0].cyc - t0, ea.cyc);
            end
        end
        tick(2);
    endtask

    task automatic test_rr();
        ack_t ea;
        clear_logs();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        slave_data_base = 32'h5000_0000;
        exp_acks.push_back('{1'b0, {rd_model(32'h40C), rd_model(32'h408), rd_model(32'h404), rd_model(32'h400)}, 1'b0, 1'b0, 0});
        exp_acks.push_back('{1'b1, {rd_model(32'h50C), rd_model(32'h508), rd_model(32'h504), rd_model(32'h500)}, 1'b0, 1'b0, 0});
        exp_acks.push_back('{1'b0, {rd_model(32'h44C), rd_model(32'h448), rd_model(32'h444), rd_model(32'h440)}, 1'b0, 1'b0, 0});
        @(negedge clk);
        l1i_req_addr = 32'h400;
        l1d_req_addr = 32'h500;
        l1d_req_we   = 1'b0;
        l1d_req_nc   = 1'b0;
        l1i_req_val  = 1'b1;
        l1d_req_val  = 1'b1;
        wait_acks(1);
        @(negedge clk);
        l1i_req_addr = 32'h440;
        l1i_req_val  = 1'b1;
        wait_acks(3);
        n_cmp++;
        if (ack_log.size() != 3) begin
            n_fail++;
            $display("FAIL rr_count: acks=%0d required 3", ack_log.size());
        end
        for (int i = 0; i < 3 && i < ack_log.size(); i++) begin
            ea = exp_acks.pop_front();
            n_cmp++;
            if (ack_log[i].is_d !== ea.is_d || ack_log[i].data !== ea.data) begin
                n_fail++;
                $display("FAIL rr_order%0d: d=%b data=%h required d=%b data=%h",
                         i, ack_log[i].is_d, ack_log[i].data, ea.is_d, ea.data);
            end
        end
        tick(2);
    endtask

    task automatic test_store();
        beat_t eb;
        clear_logs();
        exp_beats.push_back('{32'h204, 4'b0011, 1'b1, 32'hDEADBEEF, 1, 1'b1});
        @(negedge clk);
        l1d_req_addr  = 32'h204;
        l1d_req_we    = 1'b1;
        l1d_req_nc    = 1'b0;
        l1d_req_be    = 4'b0011;
        l1d_req_wdata = 32'hDEADBEEF;
        l1d_req_val   = 1'b1;
        t0 = cyc_cnt;
        wait_acks(1);
        l1d_req_we = 1'b0;
        n_cmp++;
        if (beat_log.size() != 1 || ack_log.size() != 1) begin
            n_fail++;
            $display("FAIL store_count: beats=%0d acks=%0d required 1/1", beat_log.size(), ack_log.size());
        end
        if (beat_log.size() > 0) begin
            eb = exp_beats.pop_front();
            n_cmp++;
            if (beat_log[0].adr !== eb.adr || beat_log[0].sel !== eb.sel ||
                beat_log[0].we !== eb.we || beat_log[0].dat !== eb.dat) begin
                n_fail++;
                $display("FAIL store_beat: adr=%h sel=%b we=%b dat=%h required adr=%h sel=%b we=%b dat=%h",
                         beat_log[0].adr, beat_log[0].sel, beat_log[0].we, beat_log[0].dat,
                         eb.adr, eb.sel, eb.we, eb.dat);
            end
        end
        if (ack_log.size() > 0) begin
            n_cmp++;
            if (ack_log[0].is_d !== 1'b1 || ack_log[0].we !== 1'b1 || ack_log[0].nc !== 1'b0 ||
                ack_log[0].cyc - t0 != 4) begin
                n_fail++;
                $display("FAIL store_ack: d=%b we=%b nc=%b lat=%0d required d=1 we=1 nc=0 lat=4",
                         ack_log[0].is_d, ack_log[0].we, ack_log[0].nc, ack_log[0].cyc - t0);
            end
        end
        tick(2);
    endtask

    task automatic test_nc_stall();
        ack_t ea;
        clear_logs();
        slave_data_base = 32'h1234_0000;
        stall_beat = 0;
        stall_len  = 3;
        exp_acks.push_back('{1'b1, {96'h0, rd_model(32'h300)}, 1'b1, 1'b0, 7});
        @(negedge clk);
        l1d_req_addr = 32'h300;
        l1d_req_nc   = 1'b1;
        l1d_req_val  = 1'b1;
        t0 = cyc_cnt;
        wait_acks(1);
        l1d_req_nc = 1'b0;
        stall_beat = -1;
        n_cmp++;
        if (beat_log.size() != 1) begin
            n_fail++;
            $display("FAIL nc_beats: %0d required 1", beat_log.size());
        end else begin
            n_cmp++;
            if (beat_log[0].adr !== 32'h300 || beat_log[0].hold != 4 || !beat_log[0].held_ok) begin
                n_fail++;
                $display("FAIL nc_hold: adr=%h hold=%0d stable=%b required adr=300 hold=4 stable=1",
                         beat_log[0].adr, beat_log[0].hold, beat_log[0].held_ok);
            end
        end
        if (ack_log.size() > 0) begin
            ea = exp_acks.pop_front();
            n_cmp++;
            if (ack_log[0].data !== ea.data || ack_log[0].nc !== 1'b1 || ack_log[0].is_d !== 1'b1 ||
                ack_log[0].cyc - t0 != ea.cyc) begin
                n_fail++;
                $display("FAIL nc_ack: data=%h nc=%b lat=%0d required data=%h nc=1 lat=%0d",
                         ack_log[0].data, ack_log[0].nc, ack_log[0].cyc - t0, ea.data, ea.cyc);
            end
        end
        tick(2);
    endtask

    task automatic test_fill_stall();
        beat_t eb;
        ack_t ea;
        int acks_before;
        clear_logs();
        slave_data_base = 32'h7700_0000;
        stall_beat = 2;
        stall_len  = 2;
        ack_delay  = 2;
        acks_before = acks_sent;
        for (int i = 0; i < 4; i++)
            exp_beats.push_back('{32'h600 + 4*i, 4'hF, 1'b0, 32'h0, (i == 2) ? 3 : 1, 1'b1});
        exp_acks.push_back('{1'b1, {rd_model(32'h60C), rd_model(32'h608), rd_model(32'h604), rd_model(32'h600)}, 1'b0, 1'b0, 0});
        @(negedge clk);
        l1d_req_addr = 32'h608;
        l1d_req_val  = 1'b1;
        wait_acks(1);
        tick(10);
        stall_beat = -1;
        ack_delay  = 1;
        n_cmp++;
        if (ack_log.size() != 1 || acks_sent - acks_before != 4) begin
            n_fail++;
            $display("FAIL stall_counts: req_acks=%0d wb_acks=%0d required 1/4",
                     ack_log.size(), acks_sent - acks_before);
        end
        while (exp_beats.size() > 0 && beat_log.size() > 0) begin
            eb = exp_beats.pop_front();
            n_cmp++;
            if (beat_log[0].adr !== eb.adr || beat_log[0].hold != eb.hold || !beat_log[0].held_ok) begin
                n_fail++;
                $display("FAIL stall_beat: adr=%h hold=%0d stable=%b required adr=%h hold=%0d stable=1",
                         beat_log[0].adr, beat_log[0].hold, beat_log[0].held_ok, eb.adr, eb.hold);
            end
            void'(beat_log.pop_front());
        end
        if (ack_log.size() > 0) begin
            ea = exp_acks.pop_front();
            n_cmp++;
            if (ack_log[0].data !== ea.data || ack_log[0].is_d !== 1'b1 || ack_log[0].nc !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_data: data=%h required %h", ack_log[0].data, ea.data);
            end
        end
        tick(2);
    endtask

    task automatic test_reset_mid();
        ack_t ea;
        clear_logs();
        slave_data_base = 32'h3300_0000;
        ack_delay = 8;
        @(negedge clk);
        l1i_req_addr = 32'h700;
        l1i_req_val  = 1'b1;
        for (int i = 0; i < 50 && beat_log.size() < 4; i++) tick(1);
        n_cmp++;
        if (beat_log.size() != 4 || wb_cyc_o !== 1'b1 || wb_stb_o !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_pre: beats=%0d cyc=%b stb=%b required 4/1/0",
                     beat_log.size(), wb_cyc_o, wb_stb_o);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_drop: cyc=%b stb=%b required 0/0", wb_cyc_o, wb_stb_o);
        end
        l1i_req_val = 1'b0;
        ack_delay = 1;
        tick(2);
        rst = 1'b0;
        tick(12);
        n_cmp++;
        if (ack_log.size() != 0) begin
            n_fail++;
            $display("FAIL abort_noack: req_acks=%0d required 0", ack_log.size());
        end
        clear_logs();
        exp_acks.push_back('{1'b1, {rd_model(32'h80C), rd_model(32'h808), rd_model(32'h804), rd_model(32'h800)}, 1'b0, 1'b0, 0});
        @(negedge clk);
        l1d_req_addr = 32'h800;
        l1d_req_val  = 1'b1;
        wait_acks(1);
        n_cmp++;
        if (ack_log.size() != 1) begin
            n_fail++;
            $display("FAIL abort_retry: req_acks=%0d required 1", ack_log.size());
        end else begin
            ea = exp_acks.pop_front();
            n_cmp++;
            if (ack_log[0].data !== ea.data || ack_log[0].is_d !== 1'b1) begin
                n_fail++;
                $display("FAIL abort_retry_data: data=%h required %h", ack_log[0].data, ea.data);
            end
        end
        tick(2);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        test_fill();
        test_rr();
        test_store();
        test_nc_stall();
        test_fill_stall();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
